// File: rtl/config_frame_writer.sv
// config_frame_writer: turns config words into fabric frame writes.
// Each header selects a column and frame, NUM_ROWS data words follow, then a one-cycle strobe commits the frame.
module config_frame_writer #(
    parameter int          NUM_COLUMNS    = 16,
    parameter int          NUM_ROWS       = 16,
    parameter int          FRAMES_PER_COL = 20,
    parameter logic [31:0] DESYNC_WORD    = 32'hFAB0_FAB1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     word_write_strobe_i,
    input  logic [31:0]              write_data_i,
    output logic [NUM_ROWS*32-1:0]   frame_data_o,
    output logic [NUM_COLUMNS-1:0]   column_select_o,
    output logic [FRAMES_PER_COL-1:0] frame_strobe_o,
    output logic                     busy_o,
    output logic                     config_done_o,
    output logic                     error_o
);
    localparam int CW = $clog2(NUM_ROWS) + 1;
    localparam int DW = NUM_ROWS * 32;
    typedef enum logic [1:0] {HEADER, LOAD, DONE} state_t;
    state_t state, state_next;
    logic [CW-1:0] count;
    logic [4:0] frame;
    logic valid_header, is_desync, last_word;
    always_comb begin
        valid_header = 32'(write_data_i[31:24]) < NUM_COLUMNS && 32'(write_data_i[4:0]) < FRAMES_PER_COL;
        is_desync = write_data_i == DESYNC_WORD;
        last_word = 32'(count) == NUM_ROWS - 1;
        state_next = state;
        if (word_write_strobe_i)
            case (state)
                HEADER:  state_next = is_desync ? DONE : valid_header ? LOAD : HEADER;
                LOAD:    state_next = last_word ? HEADER : LOAD;
                default: state_next = state;
            endcase
    end
    assign busy_o = state == LOAD;
    assign config_done_o = state == DONE;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= HEADER;
            count <= '0;
            frame <= '0;
            frame_data_o <= '0;
            column_select_o <= '0;
            frame_strobe_o <= '0;
            error_o <= 1'b0;
        end else begin
            state <= state_next;
            frame_strobe_o <= '0;
            if (word_write_strobe_i && state == HEADER && !is_desync) begin
                if (valid_header) begin
                    column_select_o <= NUM_COLUMNS'(1) << write_data_i[31:24];
                    frame <= write_data_i[4:0];
                    count <= '0;
                end else
                    error_o <= 1'b1;
            end
            // Shift keeps row 0 in the MSBs and still works when NUM_ROWS is 1.
            if (word_write_strobe_i && state == LOAD) begin
                frame_data_o <= DW'({frame_data_o, write_data_i});
                count <= count + 1'b1;
                if (last_word)
                    frame_strobe_o <= FRAMES_PER_COL'(1) << frame;
            end
        end
    end
endmodule
